comp_accum: RTL

- Downstream consumer of the 8-bit two's-complement converter output.
- Accepts a stream of signed samples over a valid/ready handshake and sums fixed-size blocks of NUM samples into a wider signed accumulator with saturation.
- Tracks the block minimum and maximum.
- Presents each block result on an output valid/ready handshake, holding it until it is consumed.

---
 rtl/comp_accum.sv | 139 +++++++++++++
 1 files changed

// File: rtl/comp_accum.sv
// comp_accum: block accumulator for a stream of signed samples.
// Sums NUM samples per block into a saturating SW-bit signed sum and tracks
// the block minimum and maximum. Each finished block is held on the output
// handshake until the consumer takes it, and no samples are accepted meanwhile.

module comp_accum #(
    parameter int DW  = 8,
    parameter int NUM = 16,
    parameter int SW  = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic [DW-1:0] out_min,
    output logic [DW-1:0] out_max,
    output logic          out_sat
);

    localparam int CW = $clog2(NUM);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM - 1);

    // Two-state control: accumulating a block, or holding a finished result
    localparam logic [0:0] S_ACC  = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    // Saturation limits of the accumulator
    localparam logic [SW-1:0] SUM_MAX = {1'b0, {(SW-1){1'b1}}};
    localparam logic [SW-1:0] SUM_MIN = {1'b1, {(SW-1){1'b0}}};

    logic [0:0]    r_state;
    logic [SW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_sat;
    logic          r_first;
    logic [DW-1:0] r_min;
    logic [DW-1:0] r_max;

    logic [SW-1:0] r_outSum;
    logic [DW-1:0] r_outMin;
    logic [DW-1:0] r_outMax;
    logic          r_outSat;

    logic          w_inAcc;
    logic          w_accept;
    logic          w_last;
    logic          w_release;
    logic          w_clear;
    logic [SW:0]   w_sumWide;
    logic          w_overflow;
    logic [SW-1:0] w_addResult;
    logic          w_nextSat;
    logic [DW-1:0] w_nextMin;
    logic [DW-1:0] w_nextMax;

    // clr wins over a sample offered in the same cycle; in HOLD it has no effect
    assign w_inAcc   = (r_state == S_ACC);
    assign w_accept  = w_inAcc && in_valid && !clr;
    assign w_last    = w_accept && (r_cnt == LAST_IDX);
    assign w_release = (r_state == S_HOLD) && out_ready;
    assign w_clear   = w_release || (w_inAcc && clr);

    // One extra bit of headroom: a single DW-bit add can only overflow by one bit,
    // so disagreement of the top two bits flags the overflow and its direction
    assign w_sumWide   = {r_acc[SW-1], r_acc} + {{(SW+1-DW){in_data[DW-1]}}, in_data};
    assign w_overflow  = w_sumWide[SW] ^ w_sumWide[SW-1];
    assign w_addResult = w_overflow ? (w_sumWide[SW] ? SUM_MIN : SUM_MAX)
                                    : w_sumWide[SW-1:0];
    assign w_nextSat   = r_sat | w_overflow;

    // The first sample of a block seeds both trackers
    assign w_nextMin = (r_first || ($signed(in_data) < $signed(r_min))) ? in_data : r_min;
    assign w_nextMax = (r_first || ($signed(in_data) > $signed(r_max))) ? in_data : r_max;

    // Control state: finish a block on its last accepted sample, release on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ACC;
        end else begin
            case (r_state)
                S_ACC:   if (w_last)    r_state <= S_HOLD;
                S_HOLD:  if (out_ready) r_state <= S_ACC;
                default:                r_state <= S_ACC;
            endcase
        end
    end

    // Running block state: clamped sum, sample count, sticky saturation and min/max
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            r_first <= 1'b1;
            r_min   <= '0;
            r_max   <= '0;
        end else if (w_clear) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            r_first <= 1'b1;
        end else if (w_accept) begin
            r_acc   <= w_addResult;
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
            r_sat   <= w_nextSat;
            r_first <= 1'b0;
            r_min   <= w_nextMin;
            r_max   <= w_nextMax;
        end
    end

    // Result registers capture the completed block and keep it until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outSum <= '0;
            r_outMin <= '0;
            r_outMax <= '0;
            r_outSat <= 1'b0;
        end else if (w_last) begin
            r_outSum <= w_addResult;
            r_outMin <= w_nextMin;
            r_outMax <= w_nextMax;
            r_outSat <= w_nextSat;
        end
    end

    assign in_ready  = w_inAcc;
    assign out_valid = (r_state == S_HOLD);
    assign out_sum   = r_outSum;
    assign out_min   = r_outMin;
    assign out_max   = r_outMax;
    assign out_sat   = r_outSat;

endmodule
